// File: rtl/conv_encoder_punct.sv
// K=7 IEEE 802.11a convolutional encoder with per-frame puncturing (1/2, 2/3, 3/4) on AXI4-Stream.
// Optional feature macro CONV_ENC_RATE_CHECK_EN adds a sticky rate_err output for illegal RATE codes.
module conv_encoder_punct #(
  parameter int         WIDTH = 24,
  parameter logic [6:0] G0    = 7'o133,
  parameter logic [6:0] G1    = 7'o171,
  localparam int        CW    = $clog2(2*WIDTH+1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [WIDTH-1:0]   s_axis_tdata,
  input  logic [3:0]         s_axis_tuser,
  input  logic               s_axis_tlast,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [2*WIDTH-1:0] m_axis_tdata,
  output logic [CW-1:0]      m_axis_tuser,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
`ifdef CONV_ENC_RATE_CHECK_EN
  ,
  output logic               rate_err
`endif
);

  localparam logic [3:0] RATE_6M  = 4'b1011;
  localparam logic [3:0] RATE_9M  = 4'b1111;
  localparam logic [3:0] RATE_12M = 4'b1010;
  localparam logic [3:0] RATE_18M = 4'b1110;
  localparam logic [3:0] RATE_24M = 4'b1001;
  localparam logic [3:0] RATE_36M = 4'b1101;
  localparam logic [3:0] RATE_48M = 4'b1000;
  localparam logic [3:0] RATE_54M = 4'b1100;

  localparam logic [CW-1:0] CNT_R12 = CW'(2*WIDTH);
  localparam logic [CW-1:0] CNT_R23 = CW'(3*WIDTH/2);
  localparam logic [CW-1:0] CNT_R34 = CW'(4*WIDTH/3);

  typedef enum logic [1:0] {PR_12, PR_23, PR_34} punct_e;

  function automatic punct_e rate_decode(input logic [3:0] code);
    case (code)
      RATE_48M:                             return PR_23;
      RATE_9M, RATE_18M, RATE_36M, RATE_54M: return PR_34;
      default:                              return PR_12;
    endcase
  endfunction

  logic [2*WIDTH-1:0] m_tdata_q;
  logic [CW-1:0]      m_tuser_q;
  logic               m_tlast_q;
  logic               m_tvalid_q;
  logic [5:0]         state_q;
  logic               frame_start_q;
  punct_e             rate_q;

  logic               accept;
  punct_e             rate_eff;
  logic [WIDTH+5:0]   ext;
  logic [WIDTH-1:0]   a_bits;
  logic [WIDTH-1:0]   b_bits;
  logic [2*WIDTH-1:0] tdata_d;
  logic [CW-1:0]      tuser_d;
  logic [5:0]         state_d;

  assign s_axis_tready = !m_tvalid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Window bit 6 is the current input and bit 0 the oldest, so generator bit i taps window bit i.
  always_comb begin
    rate_eff = frame_start_q ? rate_decode(s_axis_tuser) : rate_q;
    ext      = {s_axis_tdata, state_q};
    a_bits   = '0;
    b_bits   = '0;
    for (int t = 0; t < WIDTH; t++) begin
      a_bits[t] = ^(ext[t +: 7] & G0);
      b_bits[t] = ^(ext[t +: 7] & G1);
    end
    tdata_d = '0;
    tuser_d = CNT_R12;
    case (rate_eff)
      PR_23: begin
        for (int p = 0; p < WIDTH/2; p++) begin
          tdata_d[3*p]   = a_bits[2*p];
          tdata_d[3*p+1] = b_bits[2*p];
          tdata_d[3*p+2] = a_bits[2*p+1];
        end
        tuser_d = CNT_R23;
      end
      PR_34: begin
        for (int q = 0; q < WIDTH/3; q++) begin
          tdata_d[4*q]   = a_bits[3*q];
          tdata_d[4*q+1] = b_bits[3*q];
          tdata_d[4*q+2] = a_bits[3*q+1];
          tdata_d[4*q+3] = b_bits[3*q+2];
        end
        tuser_d = CNT_R34;
      end
      default: begin
        for (int t = 0; t < WIDTH; t++) begin
          tdata_d[2*t]   = a_bits[t];
          tdata_d[2*t+1] = b_bits[t];
        end
      end
    endcase
    state_d = s_axis_tlast ? 6'd0 : s_axis_tdata[WIDTH-1 -: 6];
  end

  // Output register stage: loads on acceptance, holds under backpressure.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_tdata_q     <= '0;
      m_tuser_q     <= '0;
      m_tlast_q     <= 1'b0;
      m_tvalid_q    <= 1'b0;
      state_q       <= '0;
      frame_start_q <= 1'b1;
      rate_q        <= PR_12;
    end else begin
      if (accept) begin
        m_tdata_q     <= tdata_d;
        m_tuser_q     <= tuser_d;
        m_tlast_q     <= s_axis_tlast;
        m_tvalid_q    <= 1'b1;
        state_q       <= state_d;
        frame_start_q <= s_axis_tlast;
        if (frame_start_q) rate_q <= rate_eff;
      end else if (m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;

`ifdef CONV_ENC_RATE_CHECK_EN
  function automatic logic rate_legal(input logic [3:0] code);
    case (code)
      RATE_6M, RATE_9M, RATE_12M, RATE_18M,
      RATE_24M, RATE_36M, RATE_48M, RATE_54M: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  logic rate_err_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rate_err_q <= 1'b0;
    end else if (accept && frame_start_q && !rate_legal(s_axis_tuser)) begin
      rate_err_q <= 1'b1;
    end
  end

  assign rate_err = rate_err_q;
`endif

endmodule
